// File: rtl/polaris_csr_pkg.sv
// polaris_csr_pkg: CSR addresses, cause codes, mstatus bit indices and ID constants for polaris_csr_unit
package polaris_csr_pkg;
    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MBADADDR  = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MTIME     = 12'h701;
    localparam logic [11:0] CSR_MTIMECMP  = 12'h7C0;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;
    localparam logic [11:0] CSR_MIMPID    = 12'hF13;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;
    localparam int CAUSE_MTI        = 7;
    localparam int CAUSE_LOCAL_BASE = 16;
    localparam int MSTATUS_MIE      = 3;
    localparam int MSTATUS_MPIE     = 7;
    localparam logic [25:0] MISA_EXT = 26'h000100;
    localparam logic [31:0] MIMPID   = 32'h0000_0001;
endpackage

// File: rtl/polaris_csr_counter.sv
// polaris_csr_counter: wrapping W-bit counter with load; ports clk, rst, inc, we, wdat -> count
module polaris_csr_counter #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         we,
    input  logic [W-1:0] wdat,
    output logic [W-1:0] count
);
    always_ff @(posedge clk)
        count <= rst ? '0 : we ? wdat : inc ? count + 1'b1 : count;
endmodule

// File: rtl/polaris_csr_unit.sv
// polaris_csr_unit: machine-mode CSR file with counters, interrupt enables/pending and trap/mret state.
// Ports: CSR access (cadr_i/coe_i/cwe_i/cdat_i -> cdat_o/cvalid_o), trap entry (trap_i, trap_irq_i,
// cause_i, epc_i), mret_i, retire_i, tick_i, irq_i -> irq_o/irq_cause_o, mtvec_o, mepc_o, mie_o, mpie_o.
// Optional POLARIS_CSR_TIMER_EN adds mtimecmp at 0x7C0 and drives MTIP.
module polaris_csr_unit
    import polaris_csr_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int CNT_W = 64,
    parameter int NIRQ = 4,
    parameter logic [XLEN-1:0] MTVEC_RESET = {XLEN{1'b1}} << 9
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic [11:0]     cadr_i,
    input  logic            coe_i,
    input  logic            cwe_i,
    input  logic [XLEN-1:0] cdat_i,
    output logic [XLEN-1:0] cdat_o,
    output logic            cvalid_o,
    input  logic            trap_i,
    input  logic            trap_irq_i,
    input  logic [4:0]      cause_i,
    input  logic [XLEN-1:0] epc_i,
    input  logic            mret_i,
    input  logic            retire_i,
    input  logic            tick_i,
    input  logic [NIRQ-1:0] irq_i,
    output logic            irq_o,
    output logic [4:0]      irq_cause_o,
    output logic [XLEN-1:0] mtvec_o,
    output logic [XLEN-1:0] mepc_o,
    output logic            mie_o,
    output logic            mpie_o
);
    localparam logic [XLEN-1:0] MISA = {(XLEN == 64 ? 2'd2 : 2'd1), {(XLEN-28){1'b0}}, MISA_EXT};
    localparam logic [XLEN-1:0] LOCAL_MASK = XLEN'(((64'd1 << NIRQ) - 64'd1) << CAUSE_LOCAL_BASE);
`ifdef POLARIS_CSR_TIMER_EN
    localparam logic [XLEN-1:0] MIE_MASK = LOCAL_MASK | (XLEN'(1) << CAUSE_MTI);
`else
    localparam logic [XLEN-1:0] MIE_MASK = LOCAL_MASK;
`endif
    logic [XLEN-1:0]  mcause, mscratch, mbadaddr, mie_en, mip, pend, rdata;
    logic [NIRQ-1:0]  irq_q;
    logic [CNT_W-1:0] mcycle, minstret, mtime;
    logic             mtip, valid;
    polaris_csr_counter #(.W(CNT_W)) u_mcycle (.clk(clk_i), .rst(reset_i), .inc(1'b1),
        .we(cwe_i && cadr_i == CSR_MCYCLE), .wdat(cdat_i[CNT_W-1:0]), .count(mcycle));
    polaris_csr_counter #(.W(CNT_W)) u_minstret (.clk(clk_i), .rst(reset_i), .inc(retire_i),
        .we(cwe_i && cadr_i == CSR_MINSTRET), .wdat(cdat_i[CNT_W-1:0]), .count(minstret));
    polaris_csr_counter #(.W(CNT_W)) u_mtime (.clk(clk_i), .rst(reset_i), .inc(tick_i),
        .we(cwe_i && cadr_i == CSR_MTIME), .wdat(cdat_i[CNT_W-1:0]), .count(mtime));
`ifdef POLARIS_CSR_TIMER_EN
    logic [CNT_W-1:0] mtimecmp;
    logic             wr_cmp;
    assign wr_cmp = cwe_i && cadr_i == CSR_MTIMECMP;
    // A compare write is judged against the new value so MTIP drops right after rewriting mtimecmp.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            mtimecmp <= '1;
            mtip     <= 1'b0;
        end else begin
            if (wr_cmp) mtimecmp <= cdat_i[CNT_W-1:0];
            mtip <= wr_cmp ? mtime >= cdat_i[CNT_W-1:0] : mtime >= mtimecmp;
        end
    end
`else
    assign mtip = 1'b0;
`endif
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            mie_o    <= 1'b0;
            mpie_o   <= 1'b1;
            mtvec_o  <= MTVEC_RESET;
            mepc_o   <= '0;
            mcause   <= '0;
            mscratch <= '0;
            mbadaddr <= '0;
            mie_en   <= '0;
            irq_q    <= '0;
        end else begin
            if (trap_i) begin
                mepc_o <= {epc_i[XLEN-1:1], 1'b0};
                mcause <= {trap_irq_i, {(XLEN-6){1'b0}}, cause_i};
                mpie_o <= mie_o;
                mie_o  <= 1'b0;
            end else if (mret_i) begin
                mie_o  <= mpie_o;
                mpie_o <= 1'b1;
            end else if (cwe_i && cadr_i == CSR_MSTATUS) begin
                mie_o  <= cdat_i[MSTATUS_MIE];
                mpie_o <= cdat_i[MSTATUS_MPIE];
            end
            if (!trap_i && cwe_i && cadr_i == CSR_MEPC) mepc_o <= cdat_i;
            if (!trap_i && cwe_i && cadr_i == CSR_MCAUSE) mcause <= cdat_i;
            if (cwe_i && cadr_i == CSR_MTVEC) mtvec_o <= cdat_i;
            if (cwe_i && cadr_i == CSR_MSCRATCH) mscratch <= cdat_i;
            if (cwe_i && cadr_i == CSR_MBADADDR) mbadaddr <= cdat_i;
            if (cwe_i && cadr_i == CSR_MIE) mie_en <= cdat_i & MIE_MASK;
            irq_q <= irq_i;
        end
    end
    assign mip   = (XLEN'(irq_q) << CAUSE_LOCAL_BASE) | (XLEN'(mtip) << CAUSE_MTI);
    assign pend  = mip & mie_en;
    assign irq_o = mie_o & |pend;
    // Walk local lines downward so the lowest index wins; MTIP overrides all of them.
    always_comb begin
        irq_cause_o = '0;
        for (int i = NIRQ - 1; i >= 0; i--)
            if (pend[CAUSE_LOCAL_BASE + i]) irq_cause_o = 5'(CAUSE_LOCAL_BASE + i);
        if (pend[CAUSE_MTI]) irq_cause_o = 5'(CAUSE_MTI);
    end
    always_comb begin
        rdata = '0;
        valid = 1'b1;
        case (cadr_i)
            CSR_MISA:      rdata = MISA;
            CSR_MVENDORID: rdata = '0;
            CSR_MARCHID:   rdata = '0;
            CSR_MIMPID:    rdata = XLEN'(MIMPID);
            CSR_MHARTID:   rdata = '0;
            CSR_MSTATUS: begin
                rdata[MSTATUS_MIE]  = mie_o;
                rdata[MSTATUS_MPIE] = mpie_o;
            end
            CSR_MIE:       rdata = mie_en;
            CSR_MIP:       rdata = mip;
            CSR_MTVEC:     rdata = mtvec_o;
            CSR_MSCRATCH:  rdata = mscratch;
            CSR_MEPC:      rdata = mepc_o;
            CSR_MCAUSE:    rdata = mcause;
            CSR_MBADADDR:  rdata = mbadaddr;
            CSR_MCYCLE:    rdata = XLEN'(mcycle);
            CSR_MINSTRET:  rdata = XLEN'(minstret);
            CSR_MTIME:     rdata = XLEN'(mtime);
`ifdef POLARIS_CSR_TIMER_EN
            CSR_MTIMECMP:  rdata = XLEN'(mtimecmp);
`endif
            default:       valid = 1'b0;
        endcase
    end
    assign cdat_o   = rdata;
    assign cvalid_o = valid & coe_i;
endmodule

// File: tb/tb_polaris_csr_unit.sv
// tb_polaris_csr_unit: scoreboard bench for polaris_csr_unit; timer checks run when POLARIS_CSR_TIMER_EN is defined
module tb_polaris_csr_unit;
    localparam int S_RD = 0, S_VAL = 1, S_IRQ = 2, S_CAUSE = 3, S_MTVEC = 4, S_MEPC = 5, S_MIE = 6, S_MPIE = 7;
    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic [11:0] cadr_i = '0;
    logic        coe_i = 1'b0, cwe_i = 1'b0;
    logic [63:0] cdat_i = '0, cdat_o, epc_i = '0, mtvec_o, mepc_o;
    logic        cvalid_o, trap_i = 1'b0, trap_irq_i = 1'b0, mret_i = 1'b0, retire_i = 1'b0, tick_i = 1'b0;
    logic [4:0]  cause_i = '0, irq_cause_o;
    logic [3:0]  irq_i = '0;
    logic        irq_o, mie_o, mpie_o;
    typedef struct {
        string       tag;
        int          sig;
        logic [63:0] exp;
    } exp_t;
    exp_t sb[$];
    int   n_chk = 0, n_fail = 0;
    always #5 clk = ~clk;
    polaris_csr_unit dut (
        .clk_i(clk), .reset_i(reset_i), .cadr_i(cadr_i), .coe_i(coe_i), .cwe_i(cwe_i),
        .cdat_i(cdat_i), .cdat_o(cdat_o), .cvalid_o(cvalid_o), .trap_i(trap_i),
        .trap_irq_i(trap_irq_i), .cause_i(cause_i), .epc_i(epc_i), .mret_i(mret_i),
        .retire_i(retire_i), .tick_i(tick_i), .irq_i(irq_i), .irq_o(irq_o),
        .irq_cause_o(irq_cause_o), .mtvec_o(mtvec_o), .mepc_o(mepc_o), .mie_o(mie_o), .mpie_o(mpie_o)
    );
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    function automatic logic [63:0] sig_val(input int s);
        case (s)
            S_RD:    return cdat_o;
            S_VAL:   return 64'(cvalid_o);
            S_IRQ:   return 64'(irq_o);
            S_CAUSE: return 64'(irq_cause_o);
            S_MTVEC: return mtvec_o;
            S_MEPC:  return mepc_o;
            S_MIE:   return 64'(mie_o);
            S_MPIE:  return 64'(mpie_o);
            default: return 'x;
        endcase
    endfunction
    task automatic expect_sig(input string tag, input int s, input logic [63:0] v);
        exp_t e;
        e.tag = tag;
        e.sig = s;
        e.exp = v;
        sb.push_back(e);
    endtask
    task automatic observe();
        exp_t e;
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, sig_val(e.sig), e.exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic wr(input logic [11:0] a, input logic [63:0] d);
        cadr_i = a;
        cdat_i = d;
        cwe_i = 1'b1;
        step();
        cwe_i = 1'b0;
    endtask
    task automatic rd(input logic [11:0] a, input logic [63:0] exp, input logic exp_v, input string tag);
        cadr_i = a;
        coe_i = 1'b1;
        expect_sig(tag, S_RD, exp);
        expect_sig({tag, "_valid"}, S_VAL, 64'(exp_v));
        observe();
        coe_i = 1'b0;
    endtask
    initial begin
        step();
        reset_i = 1'b0;
        expect_sig("rst_mtvec", S_MTVEC, 64'hFFFF_FFFF_FFFF_FE00);
        expect_sig("rst_mie", S_MIE, 0);
        expect_sig("rst_mpie", S_MPIE, 1);
        expect_sig("rst_irq", S_IRQ, 0);
        expect_sig("rst_cause", S_CAUSE, 0);
        expect_sig("rst_mepc", S_MEPC, 0);
        observe();
        rd(12'h300, 64'h80, 1'b1, "rst_mstatus");
        rd(12'hB02, 64'h0, 1'b1, "rst_minstret");
        wr(12'h300, 64'h8);
        expect_sig("wr_mstatus_mie", S_MIE, 1);
        expect_sig("wr_mstatus_mpie", S_MPIE, 0);
        observe();
        trap_i = 1'b1; cause_i = 5'd2; epc_i = 64'h1003;
        step();
        trap_i = 1'b0;
        expect_sig("trap_mepc", S_MEPC, 64'h1002);
        expect_sig("trap_mie", S_MIE, 0);
        expect_sig("trap_mpie", S_MPIE, 1);
        observe();
        rd(12'h342, 64'h2, 1'b1, "trap_mcause");
        mret_i = 1'b1;
        step();
        mret_i = 1'b0;
        expect_sig("mret_mie", S_MIE, 1);
        expect_sig("mret_mpie", S_MPIE, 1);
        observe();
        wr(12'h304, 64'h10000);
        irq_i = 4'b0001;
        expect_sig("irq_before_edge", S_IRQ, 0);
        observe();
        step();
        expect_sig("irq_raised", S_IRQ, 1);
        expect_sig("irq_cause16", S_CAUSE, 16);
        observe();
        rd(12'h344, 64'h10000, 1'b1, "mip_local0");
        irq_i = 4'b0000;
        step();
        expect_sig("irq_dropped", S_IRQ, 0);
        observe();
        wr(12'h304, 64'hF0000);
        irq_i = 4'b0110;
        step();
        expect_sig("irq_prio", S_CAUSE, 17);
        observe();
        irq_i = 4'b0000;
        wr(12'h304, 64'h0);
        wr(12'hB00, 64'hFFFF_FFFF_FFFF_FFFF);
        rd(12'hB00, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, "mcycle_loaded");
        step();
        rd(12'hB00, 64'h0, 1'b1, "mcycle_wrap");
        retire_i = 1'b1;
        wr(12'hB02, 64'h55);
        rd(12'hB02, 64'h55, 1'b1, "minstret_wr_wins");
        step();
        retire_i = 1'b0;
        rd(12'hB02, 64'h56, 1'b1, "minstret_inc");
        step();
        rd(12'hB02, 64'h56, 1'b1, "minstret_hold");
        trap_i = 1'b1; mret_i = 1'b1; trap_irq_i = 1'b1; cause_i = 5'd5; epc_i = 64'h2001;
        wr(12'h341, 64'hABCD);
        trap_i = 1'b0; mret_i = 1'b0; trap_irq_i = 1'b0;
        expect_sig("trap_wins_mepc", S_MEPC, 64'h2000);
        expect_sig("trap_wins_mie", S_MIE, 0);
        expect_sig("trap_wins_mpie", S_MPIE, 1);
        observe();
        rd(12'h342, 64'h8000_0000_0000_0005, 1'b1, "trap_irq_mcause");
        wr(12'h301, 64'h1234);
        rd(12'h301, 64'h8000_0000_0000_0100, 1'b1, "misa_ro");
        rd(12'hF14, 64'h0, 1'b1, "mhartid");
        wr(12'h340, 64'h1234_5678_9ABC_DEF0);
        rd(12'h340, 64'h1234_5678_9ABC_DEF0, 1'b1, "mscratch");
        wr(12'h305, 64'h8000_0100);
        expect_sig("mtvec_wr", S_MTVEC, 64'h8000_0100);
        observe();
        wr(12'h123, 64'hFFFF);
        rd(12'h123, 64'h0, 1'b0, "unimpl");
        cadr_i = 12'h300;
        expect_sig("coe_low_valid", S_VAL, 0);
        observe();
`ifdef POLARIS_CSR_TIMER_EN
        wr(12'h7C0, 64'd5);
        wr(12'h304, 64'h80);
        wr(12'h300, 64'h8);
        tick_i = 1'b1;
        repeat (5) step();
        tick_i = 1'b0;
        rd(12'h701, 64'd5, 1'b1, "mtime_ticks");
        step();
        expect_sig("timer_irq", S_IRQ, 1);
        expect_sig("timer_cause", S_CAUSE, 7);
        observe();
        wr(12'h7C0, 64'd100);
        expect_sig("timer_cleared", S_IRQ, 0);
        observe();
        rd(12'h7C0, 64'd100, 1'b1, "mtimecmp_rd");
`else
        rd(12'h7C0, 64'h0, 1'b0, "mtimecmp_absent");
        wr(12'h304, 64'h80);
        rd(12'h304, 64'h0, 1'b1, "mie7_masked");
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
